load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage load/store unit. Consumes the mem_read, mem_write and funct3 fields of the decoded control word, plus the effective address and rs2 data.
- Performs one data-memory transaction per request over a read/write/resp handshake.
- Generates byte enables and lane-replicated store data; aligns and sign/zero-extends load data.
- Sits between the execute/memory pipeline register and the data cache/memory port. Stalls the pipeline while a transaction is outstanding.

Parameters:
- ADDR_W, 32, width of the effective and memory addresses.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  memory-stage instruction present.
- req_ready  out  1  unit can accept a request.
- mem_read  in  1  control word: load.
- mem_write  in  1  control word: store.
- funct3  in  3  control word: load/store size and sign (lb=000, lh=001, lw=010, lbu=100, lhu=101, sb=000, sh=001, sw=010).
- addr  in  ADDR_W  effective address (ALU output).
- store_data  in  32  rs2 value.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  misaligned or illegal request; valid with resp_valid.
- load_data  out  32  extended load result; valid with resp_valid.
- dmem_addr  out  ADDR_W  word-aligned address (addr with [1:0] forced to 00).
- dmem_read  out  1  read strobe.
- dmem_write  out  1  write strobe.
- dmem_mbe  out  4  byte-lane enable.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  read data.
- dmem_resp  in  1  memory completion.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All dmem_* outputs 0.
  - resp_valid=0, resp_err=0, load_data=0.
  - Reset asserted mid-transaction drops dmem_read and dmem_write immediately, with no completion pulse.
- States:
  - IDLE: req_ready=1.
  - BUSY: req_ready=0. dmem_addr, dmem_read, dmem_write, dmem_mbe and dmem_wdata are registered and held stable until dmem_resp.
  - DONE: req_ready=0. resp_valid=1 for exactly one cycle.
- Request acceptance:
  - A request is accepted when req_valid=1, req_ready=1, and (mem_read or mem_write).
  - A request with req_valid=1 and neither mem_read nor mem_write is a no-op: no state change, no pulse.
- Legal request: IDLE→BUSY. The dmem strobe rises on the cycle after acceptance.
- BUSY transitions:
  - BUSY with dmem_resp=1 → DONE.
  - On that edge, strobes drop and load_data is registered from dmem_rdata.
  - dmem_resp=1 in the first BUSY cycle is legal, giving a minimum latency of accept→resp_valid = 2 cycles.
- Error requests: misaligned, or mem_read and mem_write both set.
  - Misaligned means lw/sw with addr[1:0]≠0, or lh/lhu/sh with addr[0]=1.
  - State goes IDLE→DONE directly with no memory access, resp_err=1, load_data=0.
- DONE always returns to IDLE on the next cycle.
- Ignored inputs:
  - dmem_resp is ignored in IDLE and DONE.
  - Unsupported funct3 (011, 11x) is treated as an error.
- Byte enables, with o=addr[1:0]:
  - b: 0001<<o.
  - h: 0011<<o.
  - w: 1111.
  - Loads drive the same mbe as the equivalent store size.
- Store data:
  - sb: {4{store_data[7:0]}}.
  - sh: {2{store_data[15:0]}}.
  - sw: store_data.
  - dmem_wdata=0 for loads.
- Load data:
  - Select lane via dmem_rdata >> (8·o).
  - lb/lh sign-extend from bit 7/15.
  - lbu/lhu zero-extend.
  - lw passes through.
- Request capture: all request fields are captured at acceptance. Input changes during BUSY have no effect.

Decomposition:
- rv32i_types gains:
  - lsu_state_t enum (IDLE, BUSY, DONE).
  - load_funct3_t and store_funct3_t, reused.
  - Byte-enable constants MBE_B=4'b0001, MBE_H=4'b0011, MBE_W=4'b1111.
- One combinational sub-module, lsu_load_align, with inputs rdata, offset and funct3 and output extended data. It keeps the FSM file focused on sequencing.

Test Plan:
- sw at addr 0x1000_0004, store_data 0xDEADBEEF, dmem_resp after 3 cycles → dmem_addr=0x1000_0004, mbe=1111, wdata=0xDEADBEEF held 3 cycles; req_ready=0 throughout; resp_valid one cycle later with err=0.
- sb at 0x...3, data 0x000000A5 → mbe=1000, wdata=0xA5A5A5A5; lb at 0x...3 with rdata=0x80FFFFFF → load_data=0xFFFFFF80; lbu → 0x00000080.
- lh at 0x...2 with rdata=0x8001_1234 → load_data=0xFFFF8001; lhu → 0x00008001; dmem_resp on first BUSY cycle → resp_valid exactly 2 cycles after accept.
- lw at 0x...2 (misaligned) → no dmem_read ever; resp_valid=1, resp_err=1, load_data=0 on the next cycle; same outcome for mem_read=mem_write=1.
- rst_n dropped in the middle of BUSY → dmem_read=0 asynchronously, no resp_valid; after release, req_ready=1 and a new lw completes normally.
- req_valid=1 with mem_read=mem_write=0 → req_ready stays 1, no strobe; a stray dmem_resp in IDLE → no resp_valid.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types, byte-enable constants and request decode helpers for the load/store unit.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_funct3_t;

    localparam logic [3:0] MBE_B = 4'b0001;
    localparam logic [3:0] MBE_H = 4'b0011;
    localparam logic [3:0] MBE_W = 4'b1111;

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic [3:0] lsu_mbe(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   return MBE_B << offset;
            2'b01:   return MBE_H << offset;
            default: return MBE_W;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

    // Unsigned variants exist only for loads
    function automatic logic lsu_funct3_legal(input logic [2:0] funct3, input logic is_load);
        case (funct3)
            3'b000, 3'b001, 3'b010: return 1'b1;
            3'b100, 3'b101:         return is_load;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory port of the load/store unit.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       store_data;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       load_data;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_read;
    logic              dmem_write;
    logic [3:0]        dmem_mbe;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_resp;

    modport slave (
        input  req_valid, mem_read, mem_write, funct3, addr, store_data,
        output req_ready, resp_valid, resp_err, load_data,
        output dmem_addr, dmem_read, dmem_write, dmem_mbe, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport master (
        output req_valid, mem_read, mem_write, funct3, addr, store_data,
        input  req_ready, resp_valid, resp_err, load_data,
        input  dmem_addr, dmem_read, dmem_write, dmem_mbe, dmem_wdata,
        output dmem_rdata, dmem_resp
    );

endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it by load type.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0]        lane;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        lane   = rdata >> {offset, 3'b000};
        lane_b = signed'(lane[7:0]);
        lane_h = signed'(lane[15:0]);
        case (funct3)
            F3_LB:   data = 32'(lane_b);
            F3_LH:   data = 32'(lane_h);
            F3_LBU:  data = {24'b0, lane[7:0]};
            F3_LHU:  data = {16'b0, lane[15:0]};
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one data-memory transaction per accepted request,
// stalling the pipeline (req_ready low) until the completion pulse.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    localparam logic [1:0] IDLE = LSU_IDLE;
    localparam logic [1:0] BUSY = LSU_BUSY;
    localparam logic [1:0] DONE = LSU_DONE;

    logic [1:0]  state;
    logic        accept;
    logic        req_err;
    logic [2:0]  f3_p1;
    logic [1:0]  off_p1;
    logic [31:0] aligned;

    assign bus.req_ready = (state == IDLE);
    assign accept        = bus.req_valid && bus.req_ready && (bus.mem_read || bus.mem_write);
    assign req_err       = (bus.mem_read && bus.mem_write)
                         || !lsu_funct3_legal(bus.funct3, bus.mem_read)
                         || lsu_misaligned(bus.funct3[1:0], bus.addr[1:0]);

    lsu_load_align u_align (
        .rdata  (bus.dmem_rdata),
        .offset (off_p1),
        .funct3 (f3_p1),
        .data   (aligned)
    );

    // Request capture: size and lane offset steer the load alignment at completion
    always_ff @(posedge clk) begin
        if (accept) begin
            f3_p1  <= bus.funct3;
            off_p1 <= bus.addr[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.dmem_addr  <= '0;
            bus.dmem_read  <= 1'b0;
            bus.dmem_write <= 1'b0;
            bus.dmem_mbe   <= '0;
            bus.dmem_wdata <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.load_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && req_err) begin
                        state          <= DONE;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.load_data  <= '0;
                    end else if (accept) begin
                        state          <= BUSY;
                        bus.dmem_addr  <= {bus.addr[ADDR_W-1:2], 2'b00};
                        bus.dmem_read  <= bus.mem_read;
                        bus.dmem_write <= bus.mem_write;
                        bus.dmem_mbe   <= lsu_mbe(bus.funct3[1:0], bus.addr[1:0]);
                        bus.dmem_wdata <= bus.mem_write ? lsu_wdata(bus.funct3[1:0], bus.store_data) : '0;
                    end
                end
                BUSY: begin
                    if (bus.dmem_resp) begin
                        state          <= DONE;
                        bus.dmem_read  <= 1'b0;
                        bus.dmem_write <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.load_data  <= bus.dmem_read ? aligned : '0;
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; responses are checked by a queue-based scoreboard.
module tb_load_store_unit;

    typedef struct packed {
        logic        err;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp got err=%b data=%h expected no response",
                         bus.resp_err, bus.load_data);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (bus.resp_err !== e.err || (e.chk_data && bus.load_data !== e.data)) begin
                    errors++;
                    $display("FAIL resp got err=%b data=%h expected err=%b data=%h",
                             bus.resp_err, bus.load_data, e.err, e.data);
                end
            end
        end
    end

    // Called at posedge+1 with the unit idle; returns at posedge+1 with the unit idle again
    task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                          input int dly, input logic experr, input logic [3:0] embe,
                          input logic [31:0] ewd, input logic [31:0] eld);
        exp_t e;
        e.err      = experr;
        e.chk_data = rd | experr;
        e.data     = eld;
        expq.push_back(e);
        bus.req_valid  = 1'b1;
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = sd;
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble request inputs to show they were captured at acceptance
        bus.req_valid  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.funct3     = ~f3;
        bus.addr       = ~a;
        bus.store_data = ~sd;
        if (experr) begin
            check("err_no_strobe", {30'b0, bus.dmem_read, bus.dmem_write}, 32'd0);
            check("err_resp_next_cycle", {30'b0, bus.resp_valid, bus.resp_err}, 32'd3);
            @(posedge clk); #1;
            check("err_no_strobe_after", {30'b0, bus.dmem_read, bus.dmem_write}, 32'd0);
        end else begin
            for (int i = 0; i < dly; i++) begin
                check("dmem_addr", bus.dmem_addr, {a[31:2], 2'b00});
                check("dmem_strobes", {30'b0, bus.dmem_read, bus.dmem_write}, {30'b0, rd, wr});
                check("dmem_mbe", 32'(bus.dmem_mbe), 32'(embe));
                check("dmem_wdata", bus.dmem_wdata, ewd);
                check("req_ready_busy", 32'(bus.req_ready), 32'd0);
                if (i == dly - 1) begin
                    bus.dmem_resp  = 1'b1;
                    bus.dmem_rdata = rdat;
                end
                @(posedge clk); #1;
            end
            bus.dmem_resp  = 1'b0;
            bus.dmem_rdata = 32'h5A5A_5A5A;
            check("resp_latency", 32'(bus.resp_valid), 32'd1);
            check("strobes_dropped", {30'b0, bus.dmem_read, bus.dmem_write}, 32'd0);
            check("req_ready_done", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.funct3     = 3'b000;
        bus.addr       = '0;
        bus.store_data = '0;
        bus.dmem_rdata = '0;
        bus.dmem_resp  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_dmem_addr", bus.dmem_addr, 32'd0);
        check("rst_dmem_ctl", {26'b0, bus.dmem_read, bus.dmem_write, bus.dmem_mbe}, 32'd0);
        check("rst_dmem_wdata", bus.dmem_wdata, 32'd0);
        check("rst_resp", {30'b0, bus.resp_valid, bus.resp_err}, 32'd0);
        check("rst_load_data", bus.load_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //     rd    wr    f3      addr          store         rdata         dly err mbe      wdata         load
        do_req(1'b0, 1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0,        3, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        do_req(1'b0, 1'b1, 3'b000, 32'h1000_0003, 32'h0000_00A5, 32'h0,        1, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        do_req(1'b0, 1'b1, 3'b001, 32'h1000_0002, 32'h0000_BEEF, 32'h0,        2, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        do_req(1'b1, 1'b0, 3'b000, 32'h1000_0003, 32'h0,         32'h80FF_FFFF, 2, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
        do_req(1'b1, 1'b0, 3'b100, 32'h1000_0003, 32'h0,         32'h80FF_FFFF, 1, 0, 4'b1000, 32'h0, 32'h0000_0080);
        do_req(1'b1, 1'b0, 3'b001, 32'h1000_0002, 32'h0,         32'h8001_1234, 1, 0, 4'b1100, 32'h0, 32'hFFFF_8001);
        do_req(1'b1, 1'b0, 3'b101, 32'h1000_0002, 32'h0,         32'h8001_1234, 1, 0, 4'b1100, 32'h0, 32'h0000_8001);
        do_req(1'b1, 1'b0, 3'b000, 32'h1000_0001, 32'h0,         32'h0000_7F00, 1, 0, 4'b0010, 32'h0, 32'h0000_007F);
        do_req(1'b1, 1'b0, 3'b010, 32'h1000_0000, 32'h0,         32'h1234_5678, 2, 0, 4'b1111, 32'h0, 32'h1234_5678);
        // Error requests: misaligned lw, read+write together, misaligned sh, unsupported funct3
        do_req(1'b1, 1'b0, 3'b010, 32'h1000_0002, 32'h0,         32'h0,        1, 1, 4'b0000, 32'h0, 32'h0);
        do_req(1'b1, 1'b1, 3'b010, 32'h1000_0000, 32'h0,         32'h0,        1, 1, 4'b0000, 32'h0, 32'h0);
        do_req(1'b0, 1'b1, 3'b001, 32'h1000_0001, 32'h1,         32'h0,        1, 1, 4'b0000, 32'h0, 32'h0);
        do_req(1'b1, 1'b0, 3'b011, 32'h1000_0000, 32'h0,         32'h0,        1, 1, 4'b0000, 32'h0, 32'h0);

        // No-op request and stray dmem_resp while idle
        bus.req_valid = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.dmem_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("noop_req_ready", 32'(bus.req_ready), 32'd1);
            check("noop_no_strobe", {30'b0, bus.dmem_read, bus.dmem_write}, 32'd0);
            check("noop_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.dmem_resp = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a transaction
        bus.req_valid = 1'b1;
        bus.mem_read  = 1'b1;
        bus.funct3    = 3'b010;
        bus.addr      = 32'h1000_0008;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_read  = 1'b0;
        check("busy_read_before_rst", 32'(bus.dmem_read), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_read_drop", 32'(bus.dmem_read), 32'd0);
        check("rst_no_resp", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 3'b010, 32'h1000_000C, 32'h0, 32'hCAFE_F00D, 2, 0, 4'b1111, 32'h0, 32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
